// File: rtl/bythoven_pkg.sv
// Shared SRAM geometry/timing constants and the read-arbiter state encoding.
package bythoven_pkg;

    localparam int unsigned SRAM_ADDR_W    = 18;
    localparam int unsigned SRAM_DATA_W    = 16;
    localparam int unsigned SRAM_READ_WAIT = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } arb_state_e;

endpackage

// File: rtl/sram_read_arbiter_if.sv
// Requester-side bus of the SRAM read arbiter: level requests, per-port addresses,
// one-hot grant/valid pulses and the shared read word.
interface sram_read_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;

    modport master (
        output req, addr,
        input  gnt, rvalid, rdata, busy
    );

    modport slave (
        input  req, addr,
        output gnt, rvalid, rdata, busy
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational winner select: round-robin after ptr_i by default, lowest index wins
// when SRAM_ARB_FIXED_PRIO_EN is defined (the pointer port then disappears).
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
`ifndef SRAM_ARB_FIXED_PRIO_EN
    input  logic [IDX_W-1:0]   ptr_i,
`endif
    output logic [NUM_REQ-1:0] oh_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        int unsigned cand;
        cand  = 0;
        oh_o  = '0;
        idx_o = '0;
        any_o = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = k;
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = IDX_W'(cand);
            end
        end
`else
        // Search starts one past the last winner and wraps around.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(ptr_i) + k) % NUM_REQ;
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = IDX_W'(cand);
            end
        end
`endif
        oh_o[idx_o] = any_o;
    end

endmodule

// File: rtl/sram_read_arbiter.sv
// Sole owner of the async SRAM pins: arbitrates NUM_REQ readers, holds SRAM_A for
// READ_WAIT cycles, captures SRAM_D. Define SRAM_ARB_FIXED_PRIO_EN for fixed priority.
module sram_read_arbiter
    import bythoven_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned ADDR_W    = SRAM_ADDR_W,
    parameter int unsigned DATA_W    = SRAM_DATA_W,
    parameter int unsigned READ_WAIT = SRAM_READ_WAIT
) (
    input  logic                CLK,
    input  logic                RST_N,
    sram_read_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0]   SRAM_A,
    input  logic [DATA_W-1:0]   SRAM_D,
    output logic                SRAM_WE,
    output logic                SRAM_CE,
    output logic                SRAM_OE,
    output logic                SRAM_LB,
    output logic                SRAM_UB
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(READ_WAIT + 1);

    arb_state_e          state_q;
    logic [CNT_W-1:0]    wcnt_q;
    logic [NUM_REQ-1:0]  win_oh_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                busy_q;
    logic [ADDR_W-1:0]   sram_a_q;

    logic [NUM_REQ-1:0]  pick_oh_d;
    logic [IDX_W-1:0]    pick_idx_d;
    logic                pick_any_d;

`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]    ptr_q;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i (bus.req),
`ifndef SRAM_ARB_FIXED_PRIO_EN
        .ptr_i (ptr_q),
`endif
        .oh_o  (pick_oh_d),
        .idx_o (pick_idx_d),
        .any_o (pick_any_d)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            win_oh_q <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            sram_a_q <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            ptr_q    <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            case (state_q)
                IDLE, DONE: begin
                    if (pick_any_d) begin
                        state_q  <= WAIT;
                        gnt_q    <= pick_oh_d;
                        win_oh_q <= pick_oh_d;
                        sram_a_q <= bus.addr[pick_idx_d*ADDR_W +: ADDR_W];
                        wcnt_q   <= CNT_W'(1);
                        busy_q   <= 1'b1;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                        ptr_q    <= pick_idx_d;
`endif
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                WAIT: begin
                    // rvalid is registered here so it coincides with the DONE cycle.
                    if (wcnt_q == CNT_W'(READ_WAIT)) begin
                        state_q  <= DONE;
                        rdata_q  <= SRAM_D;
                        rvalid_q <= win_oh_q;
                        busy_q   <= 1'b0;
                    end else begin
                        wcnt_q <= wcnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.busy   = busy_q;
    assign SRAM_A     = sram_a_q;

    assign SRAM_WE = 1'b1;
    assign SRAM_CE = 1'b0;
    assign SRAM_OE = 1'b0;
    assign SRAM_LB = 1'b0;
    assign SRAM_UB = 1'b0;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed bench for sram_read_arbiter: default READ_WAIT=2 instance plus a READ_WAIT=4
// instance; fixed-priority expectations apply when SRAM_ARB_FIXED_PRIO_EN is defined.
module tb_sram_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #10 clk = ~clk;

    sram_read_arbiter_if #(.NUM_REQ(2), .ADDR_W(18), .DATA_W(16)) bus  ();
    sram_read_arbiter_if #(.NUM_REQ(2), .ADDR_W(18), .DATA_W(16)) bus4 ();

    logic [17:0] sram_a, sram_a4;
    logic [15:0] sram_d, sram_d4;
    logic        we, ce, oe, lb, ub;
    logic        we4, ce4, oe4, lb4, ub4;

    function automatic logic [15:0] sram_word(input logic [17:0] a);
        if (a == 18'h00010) return 16'hA5C3;
        return {a[7:0], a[15:8]} ^ 16'h5AA5 ^ {14'h0, a[17:16]};
    endfunction

    assign sram_d  = sram_word(sram_a);
    assign sram_d4 = sram_word(sram_a4);

    sram_read_arbiter #(
        .NUM_REQ(2), .ADDR_W(18), .DATA_W(16), .READ_WAIT(2)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .bus(bus),
        .SRAM_A(sram_a), .SRAM_D(sram_d),
        .SRAM_WE(we), .SRAM_CE(ce), .SRAM_OE(oe), .SRAM_LB(lb), .SRAM_UB(ub)
    );

    sram_read_arbiter #(
        .NUM_REQ(2), .ADDR_W(18), .DATA_W(16), .READ_WAIT(4)
    ) dut4 (
        .CLK(clk), .RST_N(rst_n), .bus(bus4),
        .SRAM_A(sram_a4), .SRAM_D(sram_d4),
        .SRAM_WE(we4), .SRAM_CE(ce4), .SRAM_OE(oe4), .SRAM_LB(lb4), .SRAM_UB(ub4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus.req   = '0;
        bus4.req  = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic int ord(input int i);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        return 0 + (i & 0);
`else
        return i % 2;
`endif
    endfunction

    initial begin
        logic [1:0]  eg, ev;
        logic [17:0] ea;
        bus.addr  = '0;
        bus4.addr = '0;

        // Reset state
        do_reset();
        check("rst_gnt",    32'(bus.gnt),    32'h0);
        check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("rst_rdata",  32'(bus.rdata),  32'h0);
        check("rst_busy",   32'(bus.busy),   32'h0);
        check("rst_sram_a", 32'(sram_a),     32'h0);
        check("rst_ctrl",   32'({we, ce, oe, lb, ub}),      32'b10000);
        check("rst_ctrl4",  32'({we4, ce4, oe4, lb4, ub4}), 32'b10000);
        check("rst_a4",     32'(sram_a4),    32'h0);

        // 1: single read
        bus.req  = 2'b01;
        bus.addr = {18'h0, 18'h00010};
        check("t1_c0_gnt", 32'(bus.gnt), 32'h0);
        tick();
        check("t1_c1_gnt",  32'(bus.gnt),  32'h1);
        check("t1_c1_busy", 32'(bus.busy), 32'h1);
        check("t1_c1_a",    32'(sram_a),   32'h10);
        bus.req = 2'b00;
        tick();
        check("t1_c2_gnt", 32'(bus.gnt),    32'h0);
        check("t1_c2_rv",  32'(bus.rvalid), 32'h0);
        check("t1_c2_a",   32'(sram_a),     32'h10);
        tick();
        check("t1_c3_rv",    32'(bus.rvalid), 32'h1);
        check("t1_c3_rdata", 32'(bus.rdata),  32'hA5C3);
        check("t1_c3_busy",  32'(bus.busy),   32'h0);
        tick();
        check("t1_c4_rv",    32'(bus.rvalid), 32'h0);
        check("t1_c4_busy",  32'(bus.busy),   32'h0);
        check("t1_c4_hold",  32'(bus.rdata),  32'hA5C3);

        // 2: contention, both held from cycle 0
        do_reset();
        bus.req  = 2'b11;
        bus.addr = {18'h00200, 18'h00100};
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 10) bus.req = 2'b00;
            eg = (c % 3 == 1) ? (2'b01 << ord((c - 1) / 3)) : 2'b00;
            ev = (c % 3 == 0) ? (2'b01 << ord(c / 3 - 1))   : 2'b00;
            check($sformatf("t2_c%0d_gnt", c), 32'(bus.gnt),    32'(eg));
            check($sformatf("t2_c%0d_rv",  c), 32'(bus.rvalid), 32'(ev));
            if (ev != 2'b00) begin
                ea = ev[1] ? 18'h00200 : 18'h00100;
                check($sformatf("t2_c%0d_rdata", c), 32'(bus.rdata), 32'(sram_word(ea)));
            end
        end

        // 3: address changes in the gnt cycle
        do_reset();
        bus.req  = 2'b01;
        bus.addr = {18'h0, 18'h00300};
        tick();
        check("t3_c1_gnt", 32'(bus.gnt), 32'h1);
        check("t3_c1_a",   32'(sram_a),  32'h300);
        bus.addr = {18'h0, 18'h003FF};
        bus.req  = 2'b00;
        tick();
        check("t3_c2_a", 32'(sram_a), 32'h300);
        tick();
        check("t3_c3_rv",    32'(bus.rvalid), 32'h1);
        check("t3_c3_rdata", 32'(bus.rdata),  32'(sram_word(18'h00300)));

        // 4: reset during WAIT
        do_reset();
        bus.req  = 2'b10;
        bus.addr = {18'h00444, 18'h0};
        tick();
        check("t4_c1_gnt", 32'(bus.gnt), 32'h2);
        bus.req = 2'b00;
        tick();
        rst_n = 1'b0;
        tick();
        check("t4_c3_rv",   32'(bus.rvalid), 32'h0);
        check("t4_c3_gnt",  32'(bus.gnt),    32'h0);
        check("t4_c3_busy", 32'(bus.busy),   32'h0);
        check("t4_c3_a",    32'(sram_a),     32'h0);
        rst_n    = 1'b1;
        bus.req  = 2'b10;
        bus.addr = {18'h00555, 18'h0};
        tick();
        check("t4_r1_gnt", 32'(bus.gnt),    32'h2);
        check("t4_r1_rv",  32'(bus.rvalid), 32'h0);
        bus.req = 2'b00;
        tick();
        check("t4_r2_rv", 32'(bus.rvalid), 32'h0);
        tick();
        check("t4_r3_rv",    32'(bus.rvalid), 32'h2);
        check("t4_r3_rdata", 32'(bus.rdata),  32'(sram_word(18'h00555)));

`ifdef SRAM_ARB_FIXED_PRIO_EN
        // 5: fixed priority starves req[1] while req[0] is held
        do_reset();
        bus.req  = 2'b11;
        bus.addr = {18'h00222, 18'h00111};
        for (int c = 1; c <= 12; c++) begin
            tick();
            eg = (c == 1 || c == 4 || c == 7) ? 2'b01 : ((c == 10) ? 2'b10 : 2'b00);
            ev = (c == 3 || c == 6 || c == 9) ? 2'b01 : ((c == 12) ? 2'b10 : 2'b00);
            check($sformatf("t5_c%0d_gnt", c), 32'(bus.gnt),    32'(eg));
            check($sformatf("t5_c%0d_rv",  c), 32'(bus.rvalid), 32'(ev));
            if (c == 7)  bus.req = 2'b10;
            if (c == 10) bus.req = 2'b00;
        end
        check("t5_rdata", 32'(bus.rdata), 32'(sram_word(18'h00222)));
`endif

        // 6: READ_WAIT=4 instance
        do_reset();
        bus4.req  = 2'b01;
        bus4.addr = {18'h0, 18'h01234};
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) bus4.req = 2'b00;
            check($sformatf("t6_c%0d_gnt", c), 32'(bus4.gnt),    (c == 1) ? 32'h1 : 32'h0);
            check($sformatf("t6_c%0d_rv",  c), 32'(bus4.rvalid), (c == 5) ? 32'h1 : 32'h0);
            if (c <= 4) check($sformatf("t6_c%0d_a", c), 32'(sram_a4), 32'h1234);
            if (c == 5) check("t6_rdata", 32'(bus4.rdata), 32'(sram_word(18'h01234)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
